// File: rtl/float_compare_reduce.sv
// rtl/float_compare_reduce.sv - pipelined multi-lane FP32 comparator with streaming arg-max/arg-min reducer
// The reducer consumes beats at the end of the compare pipeline, so its result lands one cycle after q.
module float_compare_reduce #(
  parameter int LANES   = 8,
  parameter int LATENCY = 2,
  parameter int IDX_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [LANES*32-1:0]  in1_i,
  input  logic [LANES*32-1:0]  in2_i,
  input  logic                 in_valid_i,
  input  logic                 in_last_i,
  input  logic [2:0]           mode_i,
  output logic [LANES-1:0]     q_o,
  output logic                 q_valid_o,
  output logic [31:0]          red_value_o,
  output logic [IDX_W-1:0]     red_index_o,
  output logic                 red_ovf_o,
  output logic                 red_valid_o
);

  localparam int LG     = $clog2(LANES);
  localparam int LANE_W = (LANES > 1) ? LG : 1;
  localparam int CNT_W  = IDX_W - LG;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic fp_eq(input logic [31:0] a, input logic [31:0] b);
    return (a == b) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
  endfunction

  // Sign-magnitude order; callers exclude NaN operands beforehand.
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    logic r;
    if (fp_eq(a, b))        r = 1'b0;
    else if (a[31] != b[31]) r = a[31];
    else if (a[31])          r = (a[30:0] > b[30:0]);
    else                     r = (a[30:0] < b[30:0]);
    return r;
  endfunction

  function automatic logic lane_cmp(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] m);
    logic lt, eq, r;
    lt = fp_lt(a, b);
    eq = fp_eq(a, b);
    case (m)
      3'd0:    r = !lt && !eq;
      3'd1:    r = !lt;
      3'd2:    r = lt;
      3'd3:    r = lt || eq;
      3'd4:    r = eq;
      3'd5:    r = !eq;
      default: r = 1'b0;
    endcase
    if (is_nan(a) || is_nan(b)) r = (m == 3'd5);
    return r;
  endfunction

  function automatic logic better(input logic [31:0] x, input logic [31:0] y, input logic mn);
    return mn ? fp_lt(x, y) : fp_lt(y, x);
  endfunction

  logic [LANES-1:0] cmp_res;

  always_comb begin
    cmp_res = '0;
    for (int l = 0; l < LANES; l++) begin
      cmp_res[l] = lane_cmp(in1_i[32*l +: 32], in2_i[32*l +: 32], mode_i);
    end
  end

  logic [LATENCY-1:0]  vld_q;
  logic [LATENCY-1:0]  last_q;
  logic [2:0]          mode_q [LATENCY];
  logic [LANES*32-1:0] a_q    [LATENCY];
  logic [LANES-1:0]    res_q  [LATENCY];

  // Data stages load only behind a valid beat so q holds between beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        mode_q[s] <= '0;
        a_q[s]    <= '0;
        res_q[s]  <= '0;
      end
    end else begin
      vld_q[0]  <= in_valid_i;
      last_q[0] <= in_valid_i & in_last_i;
      if (in_valid_i) begin
        mode_q[0] <= mode_i;
        a_q[0]    <= in1_i;
        res_q[0]  <= cmp_res;
      end
      for (int s = 1; s < LATENCY; s++) begin
        vld_q[s]  <= vld_q[s-1];
        last_q[s] <= last_q[s-1];
        if (vld_q[s-1]) begin
          mode_q[s] <= mode_q[s-1];
          a_q[s]    <= a_q[s-1];
          res_q[s]  <= res_q[s-1];
        end
      end
    end
  end

  assign q_o       = res_q[LATENCY-1];
  assign q_valid_o = vld_q[LATENCY-1];

  logic                p_vld, p_last;
  logic [2:0]          p_mode;
  logic [LANES*32-1:0] p_a;

  assign p_vld  = vld_q[LATENCY-1];
  assign p_last = last_q[LATENCY-1];
  assign p_mode = mode_q[LATENCY-1];
  assign p_a    = a_q[LATENCY-1];

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t           state_q;
  logic             kind_min_q, found_q, ovf_q;
  logic [31:0]      best_val_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      red_value_q;
  logic [IDX_W-1:0] red_index_q;
  logic             red_ovf_q, red_valid_q;

  logic              is_first, kind_min, acc_found, cur_ovf;
  logic              beat_found, new_found;
  logic [31:0]       beat_val, new_val;
  logic [LANE_W-1:0] beat_lane;
  logic [CNT_W-1:0]  cur_cnt;
  logic [IDX_W-1:0]  new_idx;

  // Per-beat winner first (lowest lane on ties), then merged into the packet accumulator.
  always_comb begin
    is_first   = (state_q == S_IDLE);
    kind_min   = is_first ? ((p_mode == 3'd2) || (p_mode == 3'd3)) : kind_min_q;
    cur_cnt    = is_first ? '0 : cnt_q;
    acc_found  = is_first ? 1'b0 : found_q;
    cur_ovf    = (is_first ? 1'b0 : ovf_q) | (!p_last && (cur_cnt == '1));
    beat_found = 1'b0;
    beat_val   = '0;
    beat_lane  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (!is_nan(p_a[32*l +: 32]) &&
          (!beat_found || better(p_a[32*l +: 32], beat_val, kind_min))) begin
        beat_found = 1'b1;
        beat_val   = p_a[32*l +: 32];
        beat_lane  = LANE_W'(l);
      end
    end
    new_found = acc_found;
    new_val   = best_val_q;
    new_idx   = best_idx_q;
    if (beat_found && (!acc_found || better(beat_val, best_val_q, kind_min))) begin
      new_found = 1'b1;
      new_val   = beat_val;
      new_idx   = (IDX_W'(cur_cnt) << LG) | IDX_W'(beat_lane);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      kind_min_q  <= 1'b0;
      found_q     <= 1'b0;
      ovf_q       <= 1'b0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      cnt_q       <= '0;
      red_value_q <= '0;
      red_index_q <= '0;
      red_ovf_q   <= 1'b0;
      red_valid_q <= 1'b0;
    end else begin
      red_valid_q <= 1'b0;
      if (p_vld) begin
        if (p_last) begin
          state_q     <= S_IDLE;
          red_valid_q <= 1'b1;
          red_value_q <= new_found ? new_val : 32'h7FC0_0000;
          red_index_q <= new_found ? new_idx : '1;
          red_ovf_q   <= cur_ovf;
          found_q     <= 1'b0;
          ovf_q       <= 1'b0;
          best_val_q  <= '0;
          best_idx_q  <= '0;
          cnt_q       <= '0;
        end else begin
          state_q     <= S_ACCUM;
          kind_min_q  <= kind_min;
          found_q     <= new_found;
          best_val_q  <= new_val;
          best_idx_q  <= new_idx;
          cnt_q       <= cur_cnt + 1'b1;
          ovf_q       <= cur_ovf;
        end
      end
    end
  end

  assign red_value_o = red_value_q;
  assign red_index_o = red_index_q;
  assign red_ovf_o   = red_ovf_q;
  assign red_valid_o = red_valid_q;

endmodule

// File: tb/tb_float_compare_reduce.sv
// tb/tb_float_compare_reduce.sv - scoreboard bench for float_compare_reduce
// Expected compare and reduction results come from an integer-key model of FP32 ordering.
module tb_float_compare_reduce;
  localparam int LANES   = 8;
  localparam int LATENCY = 2;
  localparam int IDX_W   = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [LANES*32-1:0] in1 = '0, in2 = '0;
  logic                in_valid = 1'b0, in_last = 1'b0;
  logic [2:0]          mode = '0;
  logic [LANES-1:0]    q;
  logic                q_valid, red_ovf, red_valid;
  logic [31:0]         red_value;
  logic [IDX_W-1:0]    red_index;

  float_compare_reduce #(.LANES(LANES), .LATENCY(LATENCY), .IDX_W(IDX_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in1_i(in1), .in2_i(in2), .in_valid_i(in_valid),
    .in_last_i(in_last), .mode_i(mode), .q_o(q), .q_valid_o(q_valid),
    .red_value_o(red_value), .red_index_o(red_index), .red_ovf_o(red_ovf),
    .red_valid_o(red_valid));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [LANES-1:0] q; int cyc; } q_ent_t;
  typedef struct { logic [31:0] v; logic [IDX_W-1:0] idx; logic ovf; int cyc; } r_ent_t;

  q_ent_t      q_exp[$], q_obs[$];
  r_ent_t      r_exp[$], r_obs[$];
  logic [31:0] pkt[$];
  logic        pkt_min = 1'b0, in_pkt = 1'b0;
  int          n_cmp = 0, n_bad = 0, last_drive_cyc = 0;
  q_ent_t      mon_q;
  r_ent_t      mon_r;

  always @(negedge clk) if (rst_n) begin
    if (q_valid) begin
      mon_q.q = q; mon_q.cyc = cyc; q_obs.push_back(mon_q);
    end
    if (red_valid) begin
      mon_r.v = red_value; mon_r.idx = red_index; mon_r.ovf = red_ovf; mon_r.cyc = cyc;
      r_obs.push_back(mon_r);
    end
  end

  function automatic logic fnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic logic signed [32:0] fkey(input logic [31:0] x);
    logic signed [32:0] mag;
    mag = {2'b00, x[30:0]};
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic model_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    logic signed [32:0] ka, kb;
    logic r;
    ka = fkey(a); kb = fkey(b);
    case (m)
      3'd0: r = ka > kb;
      3'd1: r = ka >= kb;
      3'd2: r = ka < kb;
      3'd3: r = ka <= kb;
      3'd4: r = ka == kb;
      3'd5: r = ka != kb;
      default: r = 1'b0;
    endcase
    if (fnan(a) || fnan(b)) r = (m == 3'd5);
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: r = {r[31], 31'd0};
      1: r = {r[31], 8'd0, r[22:0]};
      2: r = {r[31], 8'hFF, 23'd0};
      3: r = {r[31], 8'hFF, r[22:1], 1'b1};
      4: r = {r[31], 31'h3F80_0000 + 31'(r[1:0])};
      default: r = {r[31], (r[30:23] == 8'hFF) ? 8'hFE : r[30:23], r[22:0]};
    endcase
    return r;
  endfunction

  task automatic model_reduce(output r_ent_t re);
    logic found;
    logic signed [32:0] bk;
    int bi;
    found = 1'b0; bk = '0; bi = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      if (!fnan(pkt[i]) && (!found || (pkt_min ? (fkey(pkt[i]) < bk) : (fkey(pkt[i]) > bk)))) begin
        found = 1'b1; bk = fkey(pkt[i]); bi = i;
      end
    end
    re.v   = found ? pkt[bi] : 32'h7FC0_0000;
    re.idx = found ? IDX_W'(bi) : '1;
    re.ovf = (pkt.size() > (1 << IDX_W));
    re.cyc = 0;
  endtask

  task automatic drive_beat(input logic [LANES*32-1:0] a, input logic [LANES*32-1:0] b,
                            input logic last, input logic [2:0] m);
    q_ent_t qe;
    r_ent_t re;
    @(negedge clk);
    in1 = a; in2 = b; in_valid = 1'b1; in_last = last; mode = m;
    last_drive_cyc = cyc;
    for (int l = 0; l < LANES; l++) qe.q[l] = model_cmp(a[32*l +: 32], b[32*l +: 32], m);
    qe.cyc = cyc + LATENCY;
    q_exp.push_back(qe);
    if (!in_pkt) begin
      pkt_min = (m == 3'd2) || (m == 3'd3);
      in_pkt = 1'b1;
    end
    for (int l = 0; l < LANES; l++) pkt.push_back(a[32*l +: 32]);
    if (last) begin
      model_reduce(re);
      re.cyc = cyc + LATENCY + 1;
      r_exp.push_back(re);
      pkt.delete();
      in_pkt = 1'b0;
    end
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (q_obs.size() >= q_exp.size() && r_obs.size() >= r_exp.size()) break;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({q, q_valid, red_value, red_index, red_ovf, red_valid} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got q=%h qv=%b val=%h idx=%h ovf=%b rv=%b want all zero",
               q, q_valid, red_value, red_index, red_ovf, red_valid);
    end
    rst_n = 1'b1;
    drive_idle(3);
    n_cmp++;
    if ({q_valid, red_valid, q} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got qv=%b rv=%b q=%h want 0", q_valid, red_valid, q);
    end
  endtask

  task automatic test_compare();
    logic [LANES*32-1:0] a, b;
    q_ent_t qo, qe;
    r_ent_t ro, re;
    int dc;
    a = '0; b = '0;
    a[31:0] = 32'h3F80_0000; a[63:32] = 32'h8000_0000;
    drive_beat(a, b, 1'b1, 3'd0);
    dc = last_drive_cyc;
    for (int l = 0; l < LANES; l++) begin
      a[32*l +: 32] = (l < 4) ? 32'h7FC0_0000 : 32'h0000_0000;
      b[32*l +: 32] = (l < 4) ? 32'h3F80_0000 : 32'h8000_0000;
    end
    for (int m = 0; m < 6; m++) drive_beat(a, b, 1'b1, 3'(m));
    for (int i = 0; i < 40; i++) begin
      for (int l = 0; l < LANES; l++) begin
        a[32*l +: 32] = rand_fp();
        b[32*l +: 32] = ($urandom_range(0, 3) == 0) ? a[32*l +: 32] : rand_fp();
      end
      drive_beat(a, b, (i == 39) || ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
    end
    drive_idle(1);
    wait_drain(200);
    n_cmp++;
    if (q_obs.size() < 7 || q_obs[0].q[1:0] !== 2'b01 || q_obs[0].cyc != dc + 2) begin
      n_bad++;
      $display("FAIL gt_first_beat: got q=%b @%0d want q[1:0]=01 @%0d",
               (q_obs.size() > 0) ? q_obs[0].q : '0, (q_obs.size() > 0) ? q_obs[0].cyc : -1, dc + 2);
    end
    for (int m = 0; m < 6; m++) begin
      n_cmp++;
      if (q_obs.size() < 7 || q_obs[1+m].q[0] !== (m == 5)) begin
        n_bad++;
        $display("FAIL nan_mode%0d: got %b want %b", m, (q_obs.size() > 1 + m) ? q_obs[1+m].q[0] : 1'bx, (m == 5));
      end
    end
    n_cmp++;
    if (q_obs.size() < 7 || q_obs[5].q[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL eq_signed_zero: got %b want 1", (q_obs.size() > 5) ? q_obs[5].q[4] : 1'bx);
    end
    n_cmp++;
    if (q_obs.size() != q_exp.size() || r_obs.size() != r_exp.size()) begin
      n_bad++;
      $display("FAIL compare_counts: got q=%0d red=%0d want q=%0d red=%0d", q_obs.size(), r_obs.size(), q_exp.size(), r_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      qo = q_obs.pop_front(); qe = q_exp.pop_front(); n_cmp++;
      if (qo.q !== qe.q || qo.cyc != qe.cyc) begin
        n_bad++; $display("FAIL compare_q: got %b @%0d want %b @%0d", qo.q, qo.cyc, qe.q, qe.cyc);
      end
    end
    while (r_obs.size() > 0 && r_exp.size() > 0) begin
      ro = r_obs.pop_front(); re = r_exp.pop_front(); n_cmp++;
      if (ro.v !== re.v || ro.idx !== re.idx || ro.ovf !== re.ovf || ro.cyc != re.cyc) begin
        n_bad++; $display("FAIL compare_red: got %h/%0d/%b @%0d want %h/%0d/%b @%0d", ro.v, ro.idx, ro.ovf, ro.cyc, re.v, re.idx, re.ovf, re.cyc);
      end
    end
    q_obs.delete(); q_exp.delete(); r_obs.delete(); r_exp.delete();
  endtask

  task automatic test_reduce();
    logic [LANES*32-1:0] a, b;
    q_ent_t qo, qe;
    r_ent_t ro, re;
    int dc;
    b = '0;
    for (int bt = 0; bt < 3; bt++) begin
      for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h3F80_0000 | 32'(l + bt);
      if (bt == 1) a[32*5 +: 32] = 32'h4080_0000;
      if (bt == 2) a[32*2 +: 32] = 32'h4080_0000;
      b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drive_beat(a, b, bt == 2, 3'd0);
    end
    dc = last_drive_cyc;
    for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h3F80_0000 + 32'(l);
    a[32*7 +: 32] = 32'hC120_0000;
    drive_beat(a, b, 1'b0, 3'd2);
    for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h4000_0000;
    drive_beat(a, b, 1'b1, 3'd0);
    for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h7FC0_0000 | 32'(l);
    drive_beat(a, b, 1'b0, 3'd0);
    drive_beat(a, b, 1'b1, 3'd1);
    for (int p = 0; p < 6; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int bt = 0; bt < nb; bt++) begin
        for (int l = 0; l < LANES; l++) begin
          a[32*l +: 32] = rand_fp(); b[32*l +: 32] = rand_fp();
        end
        drive_beat(a, b, bt == nb - 1, 3'($urandom_range(0, 7)));
      end
      drive_idle($urandom_range(0, 2));
    end
    drive_idle(1);
    wait_drain(200);
    n_cmp++;
    if (r_obs.size() < 3 || r_obs[0].idx !== 16'd13 || r_obs[0].v !== 32'h4080_0000 || r_obs[0].cyc != dc + 3) begin
      n_bad++;
      $display("FAIL argmax_tie: got %h/%0d @%0d want 40800000/13 @%0d", (r_obs.size() > 0) ? r_obs[0].v : '0,
               (r_obs.size() > 0) ? r_obs[0].idx : '0, (r_obs.size() > 0) ? r_obs[0].cyc : -1, dc + 3);
    end
    n_cmp++;
    if (r_obs.size() < 3 || r_obs[1].idx !== 16'd7 || r_obs[1].v !== 32'hC120_0000) begin
      n_bad++;
      $display("FAIL argmin: got %h/%0d want c1200000/7", (r_obs.size() > 1) ? r_obs[1].v : '0, (r_obs.size() > 1) ? r_obs[1].idx : '0);
    end
    n_cmp++;
    if (r_obs.size() < 3 || r_obs[2].idx !== 16'hFFFF || r_obs[2].v !== 32'h7FC0_0000) begin
      n_bad++;
      $display("FAIL all_nan: got %h/%h want 7fc00000/ffff", (r_obs.size() > 2) ? r_obs[2].v : '0, (r_obs.size() > 2) ? r_obs[2].idx : '0);
    end
    n_cmp++;
    if (q_obs.size() != q_exp.size() || r_obs.size() != r_exp.size()) begin
      n_bad++;
      $display("FAIL reduce_counts: got q=%0d red=%0d want q=%0d red=%0d", q_obs.size(), r_obs.size(), q_exp.size(), r_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      qo = q_obs.pop_front(); qe = q_exp.pop_front(); n_cmp++;
      if (qo.q !== qe.q || qo.cyc != qe.cyc) begin
        n_bad++; $display("FAIL reduce_q: got %b @%0d want %b @%0d", qo.q, qo.cyc, qe.q, qe.cyc);
      end
    end
    while (r_obs.size() > 0 && r_exp.size() > 0) begin
      ro = r_obs.pop_front(); re = r_exp.pop_front(); n_cmp++;
      if (ro.v !== re.v || ro.idx !== re.idx || ro.ovf !== re.ovf || ro.cyc != re.cyc) begin
        n_bad++; $display("FAIL reduce_red: got %h/%0d/%b @%0d want %h/%0d/%b @%0d", ro.v, ro.idx, ro.ovf, ro.cyc, re.v, re.idx, re.ovf, re.cyc);
      end
    end
    q_obs.delete(); q_exp.delete(); r_obs.delete(); r_exp.delete();
  endtask

  task automatic test_back_to_back();
    logic [LANES*32-1:0] a, b;
    q_ent_t qo, qe;
    r_ent_t ro, re;
    b = '0;
    for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h3F80_0000 + 32'(l);
    drive_beat(a, b, 1'b0, 3'd0);
    drive_beat(a, b, 1'b1, 3'd0);
    for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h3F80_0000;
    a[32*3 +: 32] = 32'h40A0_0000;
    drive_beat(a, b, 1'b1, 3'd0);
    a[32*3 +: 32] = 32'hBF80_0000;
    drive_beat(a, b, 1'b1, 3'd3);
    drive_idle(1);
    wait_drain(100);
    n_cmp++;
    if (r_obs.size() < 3 || r_obs[1].cyc - r_obs[0].cyc != 1 || r_obs[1].idx !== 16'd3) begin
      n_bad++;
      $display("FAIL b2b_pulses: got gap=%0d idx=%0d want gap=1 idx=3",
               (r_obs.size() > 1) ? r_obs[1].cyc - r_obs[0].cyc : -1, (r_obs.size() > 1) ? r_obs[1].idx : '0);
    end
    n_cmp++;
    if (q_obs.size() != q_exp.size() || r_obs.size() != r_exp.size()) begin
      n_bad++;
      $display("FAIL b2b_counts: got q=%0d red=%0d want q=%0d red=%0d", q_obs.size(), r_obs.size(), q_exp.size(), r_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      qo = q_obs.pop_front(); qe = q_exp.pop_front(); n_cmp++;
      if (qo.q !== qe.q || qo.cyc != qe.cyc) begin
        n_bad++; $display("FAIL b2b_q: got %b @%0d want %b @%0d", qo.q, qo.cyc, qe.q, qe.cyc);
      end
    end
    while (r_obs.size() > 0 && r_exp.size() > 0) begin
      ro = r_obs.pop_front(); re = r_exp.pop_front(); n_cmp++;
      if (ro.v !== re.v || ro.idx !== re.idx || ro.ovf !== re.ovf || ro.cyc != re.cyc) begin
        n_bad++; $display("FAIL b2b_red: got %h/%0d/%b @%0d want %h/%0d/%b @%0d", ro.v, ro.idx, ro.ovf, ro.cyc, re.v, re.idx, re.ovf, re.cyc);
      end
    end
    q_obs.delete(); q_exp.delete(); r_obs.delete(); r_exp.delete();
  endtask

  task automatic test_overflow();
    logic [LANES*32-1:0] a, b;
    q_ent_t qo, qe;
    r_ent_t ro, re;
    int nbeats;
    b = '0;
    for (int p = 0; p < 2; p++) begin
      nbeats = (1 << IDX_W) / LANES + p;
      for (int bt = 0; bt < nbeats; bt++) begin
        for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h3F80_0000;
        if (bt == nbeats - 1) a[32*(p == 0 ? 7 : 0) +: 32] = 32'h4000_0000;
        drive_beat(a, b, bt == nbeats - 1, 3'd0);
      end
    end
    drive_beat(a, b, 1'b1, 3'd0);
    drive_idle(1);
    wait_drain(100);
    n_cmp++;
    if (r_obs.size() < 3 || r_obs[0].idx !== 16'hFFFF || r_obs[0].ovf !== 1'b0 ||
        r_obs[1].idx !== 16'd0 || r_obs[1].ovf !== 1'b1 || r_obs[2].ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_wrap: got idx0=%h ovf0=%b idx1=%h ovf1=%b ovf2=%b want ffff/0 0000/1 0",
               (r_obs.size() > 0) ? r_obs[0].idx : '0, (r_obs.size() > 0) ? r_obs[0].ovf : 1'bx,
               (r_obs.size() > 1) ? r_obs[1].idx : '0, (r_obs.size() > 1) ? r_obs[1].ovf : 1'bx,
               (r_obs.size() > 2) ? r_obs[2].ovf : 1'bx);
    end
    n_cmp++;
    if (q_obs.size() != q_exp.size() || r_obs.size() != r_exp.size()) begin
      n_bad++;
      $display("FAIL ovf_counts: got q=%0d red=%0d want q=%0d red=%0d", q_obs.size(), r_obs.size(), q_exp.size(), r_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      qo = q_obs.pop_front(); qe = q_exp.pop_front(); n_cmp++;
      if (qo.q !== qe.q || qo.cyc != qe.cyc) begin
        n_bad++; $display("FAIL ovf_q: got %b @%0d want %b @%0d", qo.q, qo.cyc, qe.q, qe.cyc);
      end
    end
    while (r_obs.size() > 0 && r_exp.size() > 0) begin
      ro = r_obs.pop_front(); re = r_exp.pop_front(); n_cmp++;
      if (ro.v !== re.v || ro.idx !== re.idx || ro.ovf !== re.ovf || ro.cyc != re.cyc) begin
        n_bad++; $display("FAIL ovf_red: got %h/%0d/%b @%0d want %h/%0d/%b @%0d", ro.v, ro.idx, ro.ovf, ro.cyc, re.v, re.idx, re.ovf, re.cyc);
      end
    end
    q_obs.delete(); q_exp.delete(); r_obs.delete(); r_exp.delete();
  endtask

  task automatic test_reset_mid_packet();
    logic [LANES*32-1:0] a, b;
    q_ent_t qo, qe;
    r_ent_t ro, re;
    b = '0;
    for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h4200_0000;
    drive_beat(a, b, 1'b0, 3'd0);
    drive_beat(a, b, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({q, q_valid, red_value, red_index, red_ovf, red_valid} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got q=%h qv=%b val=%h idx=%h ovf=%b rv=%b want all zero",
               q, q_valid, red_value, red_index, red_ovf, red_valid);
    end
    q_obs.delete(); q_exp.delete(); r_obs.delete(); r_exp.delete();
    pkt.delete(); in_pkt = 1'b0;
    rst_n = 1'b1;
    for (int l = 0; l < LANES; l++) a[32*l +: 32] = 32'h3F80_0000;
    a[32*6 +: 32] = 32'h4040_0000;
    drive_beat(a, b, 1'b1, 3'd0);
    drive_idle(1);
    wait_drain(50);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (r_obs.size() != 1 || r_obs[0].idx !== 16'd6 || r_obs[0].v !== 32'h4040_0000) begin
      n_bad++;
      $display("FAIL after_reset_packet: got pulses=%0d idx=%0d want pulses=1 idx=6",
               r_obs.size(), (r_obs.size() > 0) ? r_obs[0].idx : '0);
    end
    n_cmp++;
    if (q_obs.size() != q_exp.size() || r_obs.size() != r_exp.size()) begin
      n_bad++;
      $display("FAIL mid_reset_counts: got q=%0d red=%0d want q=%0d red=%0d", q_obs.size(), r_obs.size(), q_exp.size(), r_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      qo = q_obs.pop_front(); qe = q_exp.pop_front(); n_cmp++;
      if (qo.q !== qe.q || qo.cyc != qe.cyc) begin
        n_bad++; $display("FAIL mid_reset_q: got %b @%0d want %b @%0d", qo.q, qo.cyc, qe.q, qe.cyc);
      end
    end
    while (r_obs.size() > 0 && r_exp.size() > 0) begin
      ro = r_obs.pop_front(); re = r_exp.pop_front(); n_cmp++;
      if (ro.v !== re.v || ro.idx !== re.idx || ro.ovf !== re.ovf || ro.cyc != re.cyc) begin
        n_bad++; $display("FAIL mid_reset_red: got %h/%0d/%b @%0d want %h/%0d/%b @%0d", ro.v, ro.idx, ro.ovf, ro.cyc, re.v, re.idx, re.ovf, re.cyc);
      end
    end
    q_obs.delete(); q_exp.delete(); r_obs.delete(); r_exp.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_compare();
    test_reduce();
    test_back_to_back();
    test_overflow();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
